// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART receiver: 2-flop rxd synchroniser, mid-bit sampling FSM, valid/ready byte output.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  logic                 sync1_q;
  logic                 rxd_s_q;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!rxd_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          // A start bit that is high again at mid-bit was only a glitch.
          if (!rxd_s_q) begin
            state_d   = DATA;
            cnt_d     = '0;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          // Shifting in from the top leaves the first line bit in the LSB.
          shift_d   = {rxd_s_q, shift_q[DATA_BITS-1:1]};
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == IDX_LAST) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          if (rxd_s_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            overrun_d  = rx_valid_q && !rx_ready;
            state_d    = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BRK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BRK: begin
        // Hold off until the line returns high so a break is reported once.
        if (rxd_s_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      rxd_s_q     <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= rxd;
      rxd_s_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Receive-side stage of the UART, downstream of the serial line and upstream of the system consuming received bytes. It synchronises the asynchronous `rxd` pin and detects the start bit. It samples each bit at mid-period using a clock-cycle counter, checks the stop bit, and presents each byte on a valid/ready interface. Its line format matches the transmitter: idle-high, 1 start bit (0), DATA_BITS data bits LSB-first, 1 stop bit (1).

Parameters:
CLKS_PER_BIT, 16, clock cycles per bit period; must be even and ≥4.
DATA_BITS, 8, data bits per frame; range 5..8.

Ports:
clk  in  1  system clock; all state changes on posedge.
rst  in  1  asynchronous, active-high reset.
rxd  in  1  serial input, asynchronous to clk, idle high.
rx_data  out  DATA_BITS  received byte, LSB = first bit on the line.
rx_valid  out  1  rx_data holds an unconsumed byte.
rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready.
frame_err  out  1  one-cycle pulse: stop bit sampled as 0.
overrun  out  1  one-cycle pulse: a new byte overwrote an unconsumed one.

Behaviour:
- Reset (async assert, sync release): both synchroniser flops = 1, state = IDLE, counters = 0, shift register = 0, rx_data = 0, rx_valid = 0, frame_err = 0, overrun = 0.
- Synchroniser: 2 flops; the FSM uses only `rxd_s` (second flop output). Pin-to-FSM latency is 2 cycles.
- `cnt` counts cycles spent in the current bit window: it is set to 0 on entry to START, DATA or STOP, and on each sample taken in DATA. `H` = CLKS_PER_BIT/2.
- FSM states:
  - IDLE: if rxd_s == 0, go to START with cnt = 0.
  - START: when cnt == H-1, sample rxd_s.
    - Sample 0: go to DATA with cnt = 0 and bit_idx = 0.
    - Sample 1: glitch; return to IDLE with no output.
  - DATA: when cnt == CLKS_PER_BIT-1, sample rxd_s into shift[bit_idx], then bit_idx++ and cnt = 0. After sampling bit DATA_BITS-1, go to STOP.
  - STOP: when cnt == CLKS_PER_BIT-1, sample rxd_s.
    - Sample 1: load rx_data from the shift register, set rx_valid = 1, go to IDLE.
    - Sample 0: pulse frame_err for 1 cycle, leave rx_data and rx_valid unchanged, go to BREAK.
  - BREAK: wait until rxd_s == 1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- Sample points fall at mid-bit, H cycles after the start edge plus whole bit periods. Any activity on rxd between sample points is ignored.
- Latency: if rxd is first low at posedge 0, rx_valid is high starting posedge 2 + H + (DATA_BITS+1)·CLKS_PER_BIT. For the defaults that is posedge 154.
- Handshake:
  - rx_data is stable while rx_valid = 1.
  - rx_valid clears on the cycle after rx_valid && rx_ready.
  - rx_ready is ignored while rx_valid = 0.
  - Reception never stalls; the consumer must keep up.
- Overrun: if a byte completes while rx_valid = 1 and no handshake occurs that cycle:
  - rx_data takes the new byte and rx_valid stays 1;
  - overrun pulses for 1 cycle.
- Simultaneous completion and handshake: the new byte loads, rx_valid stays 1, no overrun.
- Back-to-back frames: a start bit directly following a stop bit is detected. The receiver is in IDLE from the cycle after the stop sample, which is half a bit before the stop bit ends.
- Reset mid-frame: the partial byte is discarded and every output returns to its reset value immediately.

Test Plan:
- Default params; send 0xA5 (line bits 0,1,0,1,0,0,1,0,1,1) with rxd first low at posedge 0 → rx_valid rises at posedge 154 with rx_data = 0xA5; rx_ready = 1 at posedge 160 → rx_valid = 0 at posedge 161; frame_err = overrun = 0 throughout.
- 3-cycle low glitch on idle rxd → no rx_valid, no frame_err; FSM back in IDLE within H+3 cycles; a following 0x3C frame is received correctly.
- Frame 0x55 with stop bit driven 0, then line held low for 40 bit periods, then released high → exactly one frame_err pulse, rx_valid stays 0, no further frames; the next 0x81 frame is received as 0x81.
- rx_ready = 0; send 0x11 then 0x22 back-to-back → after the first frame rx_data = 0x11; after the second, rx_data = 0x22, rx_valid = 1, and one overrun pulse.
- Assert rst for 1 cycle during data bit 4 of a frame → outputs go to reset values immediately; the partial frame produces no rx_valid; the next clean 0xF0 frame gives rx_data = 0xF0.
- CLKS_PER_BIT = 4, DATA_BITS = 5; send 0x13 → rx_data = 5'h13, rx_valid at posedge 2 + 2 + 6·4 = 28.
